// File: rtl/serial_bit_source_if.sv
// Handshake and serial-output bundle between an upstream word source, the
// serializer and the downstream sequence detector.
interface serial_bit_source_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             ready;
    logic             x_out;
    logic             x_valid;
    logic             done;
    logic [7:0]       word_count;

    modport master (
        output data_in,
        output load,
        input  ready,
        input  x_out,
        input  x_valid,
        input  done,
        input  word_count
    );

    modport slave (
        input  data_in,
        input  load,
        output ready,
        output x_out,
        output x_valid,
        output done,
        output word_count
    );
endinterface

// File: rtl/serial_bit_source.sv
// MSB-first parallel-to-serial stage feeding the sequence detector's x_in,
// with an optional fixed idle gap after each word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a word, ready=1, serial outputs low
// ST_SHIFT | presenting one bit per cycle, r_bit_cnt==0 on the LSB
// ST_GAP   | GAP idle cycles after a word, ready=0
module serial_bit_source #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic                clock,
    input  logic                reset,
    serial_bit_source_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] LP_LAST     = 4'(WIDTH - 1);
    localparam logic [3:0] LP_GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       r_gap_cnt;
    logic             r_x_out;
    logic             r_x_valid;
    logic             r_done;
    logic [7:0]       r_word_count;

    logic             w_ready;
    logic             w_accept;

    // ready depends only on state, bit counter and GAP, never on load
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_SHIFT: w_ready = (GAP == 0) && (r_bit_cnt == 4'd0);
            default:  w_ready = 1'b0;
        endcase
    end

    assign w_accept = bus.load && w_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= 4'd0;
            r_gap_cnt    <= 4'd0;
            r_x_out      <= 1'b0;
            r_x_valid    <= 1'b0;
            r_done       <= 1'b0;
            r_word_count <= 8'd0;
        end else if (w_accept) begin
            // MSB goes straight to the output; the register holds the rest
            r_state      <= ST_SHIFT;
            r_shift      <= {bus.data_in[WIDTH-2:0], 1'b0};
            r_bit_cnt    <= LP_LAST;
            r_x_out      <= bus.data_in[WIDTH-1];
            r_x_valid    <= 1'b1;
            r_done       <= 1'b0;
            r_word_count <= r_word_count + 8'd1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_x_out   <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_done    <= 1'b0;
                end
                ST_SHIFT: begin
                    if (r_bit_cnt == 4'd0) begin
                        r_x_out   <= 1'b0;
                        r_x_valid <= 1'b0;
                        r_done    <= 1'b0;
                        if (GAP == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= LP_GAP_LOAD;
                        end
                    end else begin
                        r_x_out   <= r_shift[WIDTH-1];
                        r_x_valid <= 1'b1;
                        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt - 4'd1;
                        r_done    <= (r_bit_cnt == 4'd1);
                    end
                end
                ST_GAP: begin
                    r_x_out   <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_done    <= 1'b0;
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_x_out   <= 1'b0;
                    r_x_valid <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready      = w_ready;
    assign bus.x_out      = r_x_out;
    assign bus.x_valid    = r_x_valid;
    assign bus.done       = r_done;
    assign bus.word_count = r_word_count;

endmodule
